fifo_sclk_ctrl: RTL and testbench
=================================

FIFO_SCLK_CTRL -- requirements
Module: fifo_sclk_ctrl

Interface
REQ-001 SHALL have parameter LINE_SIZE, default 12, data word width in bits.
REQ-002 SHALL have parameter BLOCK_SIZE, default 8, storage depth in words.
REQ-003 SHALL have parameter ADDRESS_SIZE, default 3, pointer width; BLOCK_SIZE = 2**ADDRESS_SIZE.
REQ-004 SHALL have parameter ALMOST_FULL, default 6, count at or above which almost_full asserts.
REQ-005 SHALL have parameter ALMOST_EMPTY, default 2, count at or below which almost_empty asserts.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_L  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port init  input  1  synchronous flush of pointers, count and error.
REQ-009 SHALL have port push  input  1  write request.
REQ-010 SHALL have port data_in  input  LINE_SIZE  write data.
REQ-011 SHALL have port pop  input  1  read request.
REQ-012 SHALL have port data_out  output  LINE_SIZE  registered read data.
REQ-013 SHALL have port valid_out  output  1  data_out holds a popped word this cycle.
REQ-014 SHALL have port full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-015 SHALL have port count  output  ADDRESS_SIZE+1  current occupancy, 0..BLOCK_SIZE.
REQ-016 SHALL have port error  output  1  sticky overflow/underflow indicator.

Function
REQ-017 SHALL hold BLOCK_SIZE x LINE_SIZE storage plus wr_ptr and rd_ptr, each ADDRESS_SIZE bits, wrapping BLOCK_SIZE-1 -> 0.
REQ-018 SHALL implement FSM states RESET, INIT, IDLE, ACTIVE, ERROR.
REQ-019 SHALL transition: RESET -> INIT on first edge after reset_L high; INIT -> IDLE next edge; any state -> INIT when init=1; IDLE -> ACTIVE on accepted push; ACTIVE -> IDLE when count becomes 0; IDLE/ACTIVE -> ERROR on overflow or underflow; ERROR exits only via init or reset.
REQ-020 SHALL accept push only in IDLE/ACTIVE: push=1 and (count<BLOCK_SIZE or accepted pop same cycle) writes data_in at wr_ptr, increments wr_ptr.
REQ-021 SHALL accept pop only in ACTIVE (count>0): reads word at rd_ptr, increments rd_ptr; data_out and valid_out=1 appear the following cycle (1-cycle latency).
REQ-022 SHALL drive valid_out=0 in every cycle not following an accepted pop; data_out SHALL hold its last value when valid_out=0.
REQ-023 SHALL update count: +1 push only, -1 pop only, unchanged for simultaneous accepted push and pop.
REQ-024 SHALL, when full and push+pop together, accept both; count stays BLOCK_SIZE; no error.
REQ-025 SHALL, when empty and push+pop together, accept push, reject pop (no bypass), and flag underflow.
REQ-026 SHALL treat push while full without pop as overflow: data dropped, pointers unchanged, error=1.
REQ-027 SHALL treat pop while empty as underflow: pointers unchanged, valid_out stays 0, error=1.
REQ-028 SHALL, in ERROR, ignore push and pop; storage, pointers, count frozen; flags keep reflecting count.
REQ-029 SHALL derive flags combinationally from count: full=(count==BLOCK_SIZE), empty=(count==0), almost_full=(count>=ALMOST_FULL), almost_empty=(count<=ALMOST_EMPTY).
REQ-030 SHALL make init take priority over push/pop in the same cycle; init clears pointers, count, error, valid_out; storage contents undefined.

Reset
REQ-031 SHALL, while reset_L=0, force state RESET, wr_ptr=rd_ptr=0, count=0, data_out=0, valid_out=0, error=0, hence empty=1, almost_empty=1, full=0, almost_full=0.
REQ-032 SHALL, on reset mid-operation, discard all queued data and resume from RESET; first push is accepted no earlier than the cycle after INIT.

Verification
REQ-033 SHALL cover: push 0xA5, 0x3C on consecutive cycles, then pop twice -> data_out 0xA5 then 0x3C, each one cycle after its pop, valid_out=1 both cycles, final count=0, empty=1.
REQ-034 SHALL cover: 8 pushes of 0..7 -> count=8, full=1, almost_full asserted from count=6; 9th push alone -> error=1, state ERROR, count stays 8.
REQ-035 SHALL cover: fill to 8, then push 0x100 with pop same cycle -> data_out=0 next cycle, count=8, error=0; subsequent 8 pops return 1..7, 0x100 (wrap-around).
REQ-036 SHALL cover: pop on empty -> error=1, valid_out=0; push+pop on empty -> count=1, error=1; init pulse -> error=0, count=0.
REQ-037 SHALL cover: reset_L driven low asynchronously mid-burst with count=5 -> outputs reach reset values without waiting for clk; after release, a pop returns valid_out=0 and sets error.

Source files
------------

// File: rtl/fifo_sclk_ctrl.sv
// Single-clock FIFO controller with a lifecycle FSM, sticky overflow/underflow
// error, 1-cycle registered read data and count-derived occupancy flags.
module fifo_sclk_ctrl #(
  parameter int unsigned LINE_SIZE    = 12,
  parameter int unsigned BLOCK_SIZE   = 8,
  parameter int unsigned ADDRESS_SIZE = 3,
  parameter int unsigned ALMOST_FULL  = 6,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic                    clk,
  input  logic                    reset_L,
  input  logic                    init,
  input  logic                    push,
  input  logic [LINE_SIZE-1:0]    data_in,
  input  logic                    pop,
  output logic [LINE_SIZE-1:0]    data_out,
  output logic                    valid_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    error
);

  localparam int unsigned AW = ADDRESS_SIZE;
  localparam int unsigned CW = ADDRESS_SIZE + 1;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  error_q, error_d;
  logic                  valid_q, valid_d;
  logic [LINE_SIZE-1:0]  dout_q, dout_d;
  logic [LINE_SIZE-1:0]  mem_q [BLOCK_SIZE];

  logic live;
  logic is_full, is_empty;
  logic push_acc, pop_acc, ovf, unf, wr_en;

  assign is_full  = (count_q == CW'(BLOCK_SIZE));
  assign is_empty = (count_q == CW'(0));

  // Transfer qualification: pops need stored data, a push into a full FIFO
  // is only legal when a pop frees a slot in the same cycle.
  assign live     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign pop_acc  = !init && (state_q == ST_ACTIVE) && pop && !is_empty;
  assign unf      = !init && live && pop && is_empty;
  assign push_acc = !init && live && push && (!is_full || pop_acc);
  assign ovf      = !init && live && push && is_full && !pop_acc;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;
    valid_d  = 1'b0;
    dout_d   = dout_q;
    wr_en    = 1'b0;

    if (init) begin
      state_d  = ST_INIT;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      if (push_acc) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        valid_d  = 1'b1;
        dout_d   = mem_q[rd_ptr_q];
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (ovf || unf) begin
        error_d = 1'b1;
      end

      case (state_q)
        ST_RESET: state_d = ST_INIT;
        ST_INIT:  state_d = ST_IDLE;
        ST_IDLE: begin
          if (ovf || unf)    state_d = ST_ERROR;
          else if (push_acc) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (ovf || unf)              state_d = ST_ERROR;
          else if (count_d == CW'(0))  state_d = ST_IDLE;
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      valid_q  <= valid_d;
      dout_q   <= dout_d;
    end
  end

  // Storage needs no reset; contents are only observable after a write.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = dout_q;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign error        = error_q;
  assign full         = is_full;
  assign empty        = is_empty;
  assign almost_full  = (count_q >= CW'(ALMOST_FULL));
  assign almost_empty = (count_q <= CW'(ALMOST_EMPTY));

endmodule

// File: tb/tb_fifo_sclk_ctrl.sv
// Bench for fifo_sclk_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_sclk_ctrl;

  localparam int unsigned LW = 12;
  localparam int unsigned BS = 8;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          init, push, pop;
  logic [LW-1:0] data_in;
  logic [LW-1:0] data_out;
  logic          valid_out, full, empty, almost_full, almost_empty, error;
  logic [3:0]    count;

  int total = 0;
  int bad   = 0;

  fifo_sclk_ctrl dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .init         (init),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: occupancy as a queue, readiness as edges since reset/init.
  logic [LW-1:0] m_q[$];
  int            m_warm = 0;
  bit            m_err = 0;
  bit            m_valid = 0;
  logic [LW-1:0] m_dout = '0;
  int            m_n;
  bit            m_pa;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_q.delete();
      m_warm  = 0;
      m_err   = 0;
      m_valid = 0;
      m_dout  = '0;
    end else if (init) begin
      m_q.delete();
      m_warm  = 1;
      m_err   = 0;
      m_valid = 0;
    end else if (m_warm < 2) begin
      m_warm++;
      m_valid = 0;
    end else if (m_err) begin
      m_valid = 0;
    end else begin
      m_n     = m_q.size();
      m_pa    = pop && (m_n > 0);
      m_valid = 0;
      if (pop && m_n == 0) m_err = 1;
      if (m_pa) begin
        m_dout  = m_q.pop_front();
        m_valid = 1;
      end
      if (push) begin
        if (m_n < BS || m_pa) m_q.push_back(data_in);
        else m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("count", int'(count), m_q.size());
    chk("full", int'(full), int'(m_q.size() == BS));
    chk("empty", int'(empty), int'(m_q.size() == 0));
    chk("almost_full", int'(almost_full), int'(m_q.size() >= 6));
    chk("almost_empty", int'(almost_empty), int'(m_q.size() <= 2));
    chk("error", int'(error), int'(m_err));
    chk("valid_out", int'(valid_out), int'(m_valid));
    chk("data_out", int'(data_out), int'(m_dout));
  end

  task automatic cyc(input bit ps, input bit pp, input bit in_, input logic [LW-1:0] d);
    push    = ps;
    pop     = pp;
    init    = in_;
    data_in = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    init = 1'b0;
  endtask

  task automatic do_init();
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
  endtask

  int pp_pct;

  initial begin
    reset_L = 1'b0;
    init = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_dout", int'(data_out), 0);
    reset_L = 1'b1;
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);

    // Two pushes then two pops, data one cycle after each pop.
    cyc(1, 0, 0, 12'hA5);
    cyc(1, 0, 0, 12'h3C);
    chk("d33_count2", int'(count), 2);
    cyc(0, 1, 0, '0);
    chk("d33_v1", int'(valid_out), 1);
    chk("d33_d1", int'(data_out), 'hA5);
    cyc(0, 1, 0, '0);
    chk("d33_v2", int'(valid_out), 1);
    chk("d33_d2", int'(data_out), 'h3C);
    chk("d33_count0", int'(count), 0);
    chk("d33_empty", int'(empty), 1);
    cyc(0, 0, 0, '0);
    chk("d33_v3", int'(valid_out), 0);
    chk("d33_hold", int'(data_out), 'h3C);

    // Fill to full, then overflow.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, LW'(i));
      if (i == 4) chk("d34_af_at5", int'(almost_full), 0);
      if (i == 5) chk("d34_af_at6", int'(almost_full), 1);
    end
    chk("d34_count8", int'(count), 8);
    chk("d34_full", int'(full), 1);
    cyc(1, 0, 0, 12'h0FF);
    chk("d34_err", int'(error), 1);
    chk("d34_count", int'(count), 8);
    cyc(0, 1, 0, '0);
    chk("d34_frozen", int'(count), 8);
    chk("d34_novalid", int'(valid_out), 0);
    do_init();
    chk("d34_init_err", int'(error), 0);
    chk("d34_init_cnt", int'(count), 0);

    // Push+pop on full with wrap-around.
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, LW'(i));
    cyc(1, 1, 0, 12'h100);
    chk("d35_v", int'(valid_out), 1);
    chk("d35_d", int'(data_out), 0);
    chk("d35_cnt", int'(count), 8);
    chk("d35_err", int'(error), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, '0);
      chk("d35_pop", int'(data_out), (i == 8) ? 'h100 : i);
    end
    chk("d35_empty", int'(empty), 1);

    // Underflow cases.
    cyc(0, 1, 0, '0);
    chk("d36_err", int'(error), 1);
    chk("d36_valid", int'(valid_out), 0);
    do_init();
    cyc(1, 1, 0, 12'h055);
    chk("d36_cnt1", int'(count), 1);
    chk("d36_err2", int'(error), 1);
    chk("d36_valid2", int'(valid_out), 0);
    cyc(0, 0, 1, '0);
    chk("d36_init_err", int'(error), 0);
    chk("d36_init_cnt", int'(count), 0);
    cyc(0, 0, 0, '0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      pp_pct = (i % 200 < 100) ? 70 : 30;
      cyc($urandom_range(0, 99) < pp_pct, $urandom_range(0, 99) < 100 - pp_pct,
          $urandom_range(0, 99) < 3, LW'($urandom));
    end
    do_init();

    // Asynchronous reset mid-burst.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, LW'(8'h40 + i));
    chk("d37_cnt5", int'(count), 5);
    #2;
    reset_L = 1'b0;
    #1;
    chk("d37_cnt", int'(count), 0);
    chk("d37_empty", int'(empty), 1);
    chk("d37_aempty", int'(almost_empty), 1);
    chk("d37_full", int'(full), 0);
    chk("d37_error", int'(error), 0);
    chk("d37_valid", int'(valid_out), 0);
    chk("d37_dout", int'(data_out), 0);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 0, '0);
    chk("d37_pop_valid", int'(valid_out), 0);
    chk("d37_pop_err", int'(error), 1);
    cyc(0, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
